// File: rtl/ibex_pext_mac32.sv
// Multi-cycle 32x32 multiply-accumulate for the P-extension MAC group.
// Builds the 64-bit product from four 17x17 partial products, then accumulates into rd.
module ibex_pext_mac32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        kill_i,
  input  logic        high_i,
  input  logic        signed_ops_i,
  input  logic [1:0]  alu_sub_i,
  input  logic        rounding_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [31:0] acc_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o,
  output logic        sat_o
);

  // state | meaning
  // IDLE  | waiting for valid_i
  // MUL   | one partial product per cycle, pp_cnt 0..3
  // ACC   | accumulate, round, saturate; register result
  // DONE  | result strobe
  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_e;

  state_e      state_q;
  logic [1:0]  pp_cnt_q;
  logic [63:0] p_q;
  logic [31:0] a_q, b_q, acc_q, result_q;
  logic        high_q, signed_q, sub_q, round_q, sat_q;

  logic [16:0]        a_lo, a_hi, b_lo, b_hi, opx, opy;
  logic [5:0]         shamt;
  logic signed [33:0] pp;
  logic [63:0]        pp_ext, p_d;

  always_comb begin
    a_lo  = {1'b0, a_q[15:0]};
    b_lo  = {1'b0, b_q[15:0]};
    a_hi  = {signed_q & a_q[31], a_q[31:16]};
    b_hi  = {signed_q & b_q[31], b_q[31:16]};
    opx   = a_lo;
    opy   = b_lo;
    shamt = 6'd0;
    case (pp_cnt_q)
      2'd0: begin opx = a_lo; opy = b_lo; shamt = 6'd0;  end
      2'd1: begin opx = a_lo; opy = b_hi; shamt = 6'd16; end
      2'd2: begin opx = a_hi; opy = b_lo; shamt = 6'd16; end
      default: begin opx = a_hi; opy = b_hi; shamt = 6'd32; end
    endcase
    pp     = $signed(opx) * $signed(opy);
    pp_ext = {{30{pp[33]}}, pp};
    p_d    = p_q + (pp_ext << shamt);
  end

  logic [31:0] low_x, low_res, h_raw, h_rnd, h_sel, acc_res;
  logic [32:0] s33;
  logic        ovf, unf, acc_sat;

  always_comb begin
    low_x   = p_q[31:0];
    low_res = sub_q ? (acc_q - low_x) : (acc_q + low_x);
    h_raw   = p_q[63:32];
    // Adding 2^31 carries into bit 32 exactly when P[31] is set.
    h_rnd   = p_q[63:32] + {31'd0, p_q[31]};
    h_sel   = round_q ? h_rnd : h_raw;
    s33     = sub_q ? ({acc_q[31], acc_q} - {h_sel[31], h_sel})
                    : ({acc_q[31], acc_q} + {h_sel[31], h_sel});
    ovf     = ~s33[32] & s33[31];
    unf     = s33[32] & ~s33[31];
    acc_res = low_res;
    acc_sat = 1'b0;
    if (high_q) begin
      acc_sat = ovf | unf;
      if (ovf)      acc_res = 32'h7FFF_FFFF;
      else if (unf) acc_res = 32'h8000_0000;
      else          acc_res = s33[31:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      pp_cnt_q <= 2'd0;
      p_q      <= 64'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      acc_q    <= 32'd0;
      high_q   <= 1'b0;
      signed_q <= 1'b0;
      sub_q    <= 1'b0;
      round_q  <= 1'b0;
      result_q <= 32'd0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && !kill_i) begin
            a_q      <= op_a_i;
            b_q      <= op_b_i;
            acc_q    <= acc_i;
            high_q   <= high_i;
            signed_q <= signed_ops_i;
            sub_q    <= (alu_sub_i == 2'b11);
            round_q  <= rounding_i;
            p_q      <= 64'd0;
            pp_cnt_q <= 2'd0;
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            p_q      <= p_d;
            pp_cnt_q <= pp_cnt_q + 2'd1;
            if (pp_cnt_q == 2'd3) state_q <= ACC;
          end
        end
        ACC: begin
          if (kill_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= acc_res;
            sat_q    <= acc_sat;
            state_q  <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign valid_o  = (state_q == DONE);
  assign sat_o    = (state_q == DONE) & sat_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ibex_pext_mac32.sv
// Directed self-checking bench for ibex_pext_mac32: MAC results, latency, kill and reset.
module tb_ibex_pext_mac32;
  logic        clk = 1'b0;
  logic        rst_i, valid_i, kill_i, high_i, signed_ops_i, rounding_i;
  logic [1:0]  alu_sub_i;
  logic [31:0] op_a_i, op_b_i, acc_i;
  logic        busy_o, valid_o, sat_o;
  logic [31:0] result_o;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ibex_pext_mac32 dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .kill_i(kill_i),
    .high_i(high_i), .signed_ops_i(signed_ops_i), .alu_sub_i(alu_sub_i),
    .rounding_i(rounding_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .acc_i(acc_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o), .sat_o(sat_o)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                         input logic hi, input logic sg, input logic [1:0] sub, input logic rnd);
    op_a_i = a; op_b_i = b; acc_i = acc;
    high_i = hi; signed_ops_i = sg; alu_sub_i = sub; rounding_i = rnd;
  endtask

  // Assumes the DUT is idle and operands are set; expects the strobe in cycle 6.
  task automatic launch(input string tag, input logic [31:0] er, input logic es);
    int cyc = 0;
    valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      cyc++;
      if (valid_o) break;
    end
    check_val({tag, "_lat"}, cyc, 32'd6);
    check_val({tag, "_res"}, result_o, er);
    check_val({tag, "_sat"}, {31'd0, sat_o}, {31'd0, es});
    @(posedge clk); #1;
    check_val({tag, "_strobe_end"}, {30'd0, valid_o, sat_o}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic hi, input logic sg,
                        input logic [1:0] sub, input logic rnd,
                        input logic [31:0] er, input logic es);
    for (int i = 0; i < 20 && busy_o; i++) @(negedge clk);
    set_ops(a, b, acc, hi, sg, sub, rnd);
    launch(tag, er, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    rst_i = 1'b1; valid_i = 1'b0; kill_i = 1'b0;
    set_ops(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_outs", {29'd0, busy_o, valid_o, sat_o}, 32'd0);
    check_val("rst_res", result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b0;

    run_op("maddr",     32'd3, 32'd5, 32'd10, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0019, 1'b0);
    run_op("maddr_s01", 32'd3, 32'd5, 32'd10, 1'b0, 1'b0, 2'b01, 1'b0, 32'h0000_0019, 1'b0);
    run_op("msubr",     32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0002, 1'b0);
    run_op("kmmac_ovf", 32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 2'b00, 1'b0, 32'h7FFF_FFFF, 1'b1);
    run_op("kmmsb_unf", 32'h4000_0000, 32'h4000_0000, 32'h8000_0000, 1'b1, 1'b1, 2'b11, 1'b0, 32'h8000_0000, 1'b1);
    run_op("kmmacu_r1", 32'h0001_0000, 32'h0000_8000, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0001, 1'b0);
    run_op("kmmac_r0",  32'h0001_0000, 32'h0000_8000, 32'd0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0000, 1'b0);
    run_op("max_nosat", 32'h0001_0000, 32'h0001_0000, 32'h7FFF_FFFE, 1'b1, 1'b1, 2'b00, 1'b0, 32'h7FFF_FFFF, 1'b0);
    run_op("min_nosat", 32'h0001_0000, 32'h0001_0000, 32'h8000_0001, 1'b1, 1'b1, 2'b11, 1'b0, 32'h8000_0000, 1'b0);
    run_op("uns_high",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFE, 1'b0);
    run_op("neg_r0",    32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("neg_r1",    32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h0000_0000, 1'b0);
    run_op("sgn_high",  32'h8000_0000, 32'h8000_0000, 32'd5, 1'b1, 1'b1, 2'b00, 1'b0, 32'h4000_0005, 1'b0);

    // kill in cycle 3, new op accepted in cycle 4
    for (int i = 0; i < 20 && busy_o; i++) @(negedge clk);
    set_ops(32'd3, 32'd5, 32'd10, 1'b0, 1'b0, 2'b00, 1'b0);
    valid_i = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      seen |= valid_o;
    end
    kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    seen |= valid_o;
    check_val("kill_nostrobe", {31'd0, seen}, 32'd0);
    check_val("kill_busy_c4", {31'd0, busy_o}, 32'd0);
    check_val("kill_res_held", result_o, 32'h4000_0005);
    set_ops(32'd7, 32'd6, 32'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    launch("kill_new", 32'd43, 1'b0);

    // kill together with valid in IDLE: not accepted
    @(negedge clk);
    valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check_val("kill_idle_busy", {31'd0, busy_o}, 32'd0);

    // reset in cycle 5 (ACC)
    @(negedge clk);
    set_ops(32'h4000_0000, 32'h4000_0000, 32'h7FFF_FFFF, 1'b1, 1'b1, 2'b00, 1'b0);
    valid_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
    end
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    check_val("rst_mid_outs", {29'd0, busy_o, valid_o, sat_o}, 32'd0);
    check_val("rst_mid_res", result_o, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      seen |= valid_o | busy_o;
    end
    check_val("rst_mid_quiet", {31'd0, seen}, 32'd0);

    // valid pulse during busy is ignored
    @(negedge clk);
    set_ops(32'd4, 32'd4, 32'd1, 1'b0, 1'b0, 2'b00, 1'b0);
    valid_i = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      valid_i = 1'b0;
      if (c == 2) begin
        set_ops(32'd100, 32'd100, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        valid_i = 1'b1;
      end
      if (c < 6) seen |= valid_o;
    end
    check_val("busyv_early", {31'd0, seen}, 32'd0);
    check_val("busyv_strobe", {31'd0, valid_o}, 32'd1);
    check_val("busyv_res", result_o, 32'd17);
    @(posedge clk); #1;
    check_val("busyv_c7", {31'd0, busy_o}, 32'd0);
    @(posedge clk); #1;
    check_val("busyv_c8", {31'd0, busy_o}, 32'd0);
    check_val("busyv_hold", result_o, 32'd17);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
